// File: rtl/load_store_unit.sv
// Load/store unit: one CPU access at a time against a single-ported word memory,
// with read-modify-write for sub-word stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [29:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_input,
    input  logic [31:0] mem_read_result
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready;
    // the response is a single resp_valid pulse with no backpressure.
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [29:0] word_q;
    logic [31:0] data_q;

    logic [1:0]  size_eff;
    logic [1:0]  off_eff;
    logic        trap;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign size_eff = (req_size == 2'b11) ? 2'b10 : req_size;
    assign off_eff  = (size_eff == 2'b00) ? req_address[1:0] :
                      (size_eff == 2'b01) ? {req_address[1], 1'b0} : 2'b00;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((req_size == 2'b01) && req_address[0]) ||
                  ((req_size == 2'b10) && (req_address[1:0] != 2'b00)) ||
                  (req_size == 2'b11);
`else
    assign trap = 1'b0;
`endif

    assign lane_b = mem_read_result[{off_q, 3'b000} +: 8];
    assign lane_h = off_q[1] ? mem_read_result[31:16] : mem_read_result[15:0];

    always_comb begin
        load_ext = mem_read_result;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_read_result;
        endcase
    end

    // Sub-word store: keep the fetched word, overwrite only the addressed lane(s).
    always_comb begin
        merged = mem_read_result;
        case (size_q)
            2'b00: merged[{off_q, 3'b000} +: 8] = data_q[7:0];
            2'b01: begin
                if (off_q[1]) merged[31:16] = data_q[15:0];
                else          merged[15:0]  = data_q[15:0];
            end
            default: merged = data_q;
        endcase
    end

    assign req_ready        = (state == IDLE) && !reset;
    assign mem_address      = ((state == READ) || (state == WRITE)) ? word_q : 30'd0;
    assign mem_write_enable = (state == WRITE);
    assign mem_write_input  = (state == WRITE) ? data_q : 32'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            word_q     <= 30'd0;
            data_q     <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        size_q   <= size_eff;
                        off_q    <= off_eff;
                        word_q   <= req_address[31:2];
                        data_q   <= req_wdata;
                        if (trap) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (req_write && (size_eff == 2'b10)) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (write_q) begin
                        data_q <= merged;
                        state  <= WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_ext;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a behavioural word memory and an
// expected-response queue; expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_address = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [29:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_input;
    logic [31:0] mem_read_result;

    logic [31:0] mem [0:63];
    logic [32:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    logic [29:0] last_waddr = 30'd0;
    logic [31:0] last_wdata = 32'd0;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .mem_write_input(mem_write_input),
        .mem_read_result(mem_read_result)
    );

    always #5 clock = ~clock;

    assign mem_read_result = mem[mem_address[5:0]];

    always @(posedge clock) begin
        if (mem_write_enable) begin
            mem[mem_address[5:0]] <= mem_write_input;
            wr_count   <= wr_count + 1;
            last_waddr <= mem_address;
            last_wdata <= mem_write_input;
        end
    end

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d, input logic [32:0] exp);
        int n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: req_ready=%0b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_address = a; req_wdata = d;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        req_valid   = 1'b0;
        req_write   = 1'($urandom_range(0, 1));
        req_size    = 2'($urandom_range(0, 3));
        req_signed  = 1'($urandom_range(0, 1));
        req_address = $urandom;
        req_wdata   = $urandom;
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_write_enable} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000",
                     {req_ready, resp_valid, resp_error, mem_write_enable});
        end
        checks++;
        if ((resp_rdata | mem_write_input | {2'b00, mem_address}) !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h winput=%h addr=%h required 0",
                     resp_rdata, mem_write_input, mem_address);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic test_word();
        int lat;
        int wr0 = wr_count;
        logic [32:0] e;
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD, 33'd0);
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 2 || {resp_error, resp_rdata} !== e) begin
            errors++;
            $display("FAIL sw_resp: lat=%0d data=%h required lat=2 data=%h", lat, {resp_error, resp_rdata}, e);
        end
        checks++;
        if (wr_count !== wr0 + 1 || last_waddr !== 30'd4 || last_wdata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL sw_write: n=%0d addr=%h data=%h required n=%0d addr=4 data=aabbccdd",
                     wr_count - wr0, last_waddr, last_wdata, 1);
        end
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, {1'b0, 32'hAABBCCDD});
        wait_resp(lat);
        e = exp_q.pop_front();
        checks++;
        if (lat !== 2 || {resp_error, resp_rdata} !== e) begin
            errors++;
            $display("FAIL lw_resp: lat=%0d data=%h required lat=2 data=%h", lat, {resp_error, resp_rdata}, e);
        end
    endtask

    task automatic test_rmw();
        int lat;
        logic [32:0] e;
        logic [31:0] d_t [2] = '{32'hFFFFFF11, 32'h0000BEEF};
        logic [1:0]  s_t [2] = '{2'b00, 2'b01};
        logic [31:0] m_t [2] = '{32'hAA11CCDD, 32'hBEEFCCDD};
        for (int i = 0; i < 2; i++) begin
            send(1'b1, s_t[i], 1'b0, 32'h12, d_t[i], 33'd0);
            wait_resp(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== 3 || {resp_error, resp_rdata} !== e) begin
                errors++;
                $display("FAIL rmw_resp[%0d]: lat=%0d data=%h required lat=3 data=%h", i, lat, {resp_error, resp_rdata}, e);
            end
            checks++;
            if (mem[4] !== m_t[i]) begin
                errors++;
                $display("FAIL rmw_mem[%0d]: word=%h required %h", i, mem[4], m_t[i]);
            end
        end
    endtask

    task automatic test_loads();
        int lat;
        logic [32:0] e;
        logic [31:0] a_t [8] = '{32'h21, 32'h22, 32'h22, 32'h22, 32'h22, 32'h20, 32'h23, 32'h20};
        logic [1:0]  s_t [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
        logic        g_t [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] x_t [8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF,
                                 32'h000080FF, 32'h00007F01, 32'hFFFFFF80, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            send(1'b0, s_t[i], g_t[i], a_t[i], 32'd0, {1'b0, x_t[i]});
            wait_resp(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== 2 || {resp_error, resp_rdata} !== e) begin
                errors++;
                $display("FAIL load[%0d]: lat=%0d data=%h required lat=2 data=%h", i, lat, {resp_error, resp_rdata}, e);
            end
        end
    endtask

    task automatic test_misalign();
        int lat;
        int wr0 = wr_count;
        logic [32:0] e;
        logic        w_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  s_t [4] = '{2'd2, 2'd1, 2'd3, 2'd1};
        logic [31:0] a_t [4] = '{32'h13, 32'h23, 32'h20, 32'h09};
`ifdef LSU_MISALIGN_TRAP_EN
        logic [32:0] x_t [4] = '{33'h100000000, 33'h100000000, 33'h100000000, 33'h100000000};
        int          l_t [4] = '{1, 1, 1, 1};
        logic [31:0] exp_m2 = 32'hCAFEF00D;
        int          exp_wr = 0;
`else
        logic [32:0] x_t [4] = '{33'h0BEEFCCDD, 33'h0FFFF80FF, 33'h080FF7F01, 33'h000000000};
        int          l_t [4] = '{2, 2, 2, 3};
        logic [31:0] exp_m2 = 32'hCAFE1234;
        int          exp_wr = 1;
`endif
        for (int i = 0; i < 4; i++) begin
            send(w_t[i], s_t[i], 1'b1, a_t[i], 32'h00001234, x_t[i]);
            wait_resp(lat);
            e = exp_q.pop_front();
            checks++;
            if (lat !== l_t[i] || {resp_error, resp_rdata} !== e) begin
                errors++;
                $display("FAIL misalign[%0d]: lat=%0d data=%h required lat=%0d data=%h",
                         i, lat, {resp_error, resp_rdata}, l_t[i], e);
            end
        end
        checks++;
        if (wr_count - wr0 !== exp_wr || mem[2] !== exp_m2) begin
            errors++;
            $display("FAIL misalign_mem: writes=%0d word=%h required writes=%0d word=%h",
                     wr_count - wr0, mem[2], exp_wr, exp_m2);
        end
    endtask

    task automatic test_random_bytes();
        int lat;
        logic [32:0] e;
        logic [31:0] model = $urandom;
        send(1'b1, 2'b10, 1'b0, 32'h40, model, 33'd0);
        wait_resp(lat);
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            int          off = $urandom_range(0, 3);
            logic [31:0] val = $urandom;
            model[8*off +: 8] = val[7:0];
            send(1'b1, 2'b00, 1'b0, 32'h40 + 32'(off), val, 33'd0);
            wait_resp(lat);
            e = exp_q.pop_front();
            send(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, {1'b0, model});
            wait_resp(lat);
            e = exp_q.pop_front();
            checks++;
            if ({resp_error, resp_rdata} !== e) begin
                errors++;
                $display("FAIL rand_byte[%0d]: data=%h required %h", i, {resp_error, resp_rdata}, e);
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int wr0;
        int seen = 0;
        logic [32:0] e;
        send(1'b1, 2'b10, 1'b0, 32'h08, 32'h5A5A5A5A, 33'd0);
        wait_resp(lat);
        e = exp_q.pop_front();
        wr0 = wr_count;
        send(1'b1, 2'b01, 1'b0, 32'h08, 32'h0000BEEF, 33'd0);
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if ({req_ready, mem_write_enable, resp_valid} !== 3'b0 || mem_address !== 30'd0) begin
            errors++;
            $display("FAIL midop_async: ctrl=%b addr=%h required 000 addr=0",
                     {req_ready, mem_write_enable, resp_valid}, mem_address);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        checks++;
        if (seen !== 0 || wr_count !== wr0 || mem[2] !== 32'h5A5A5A5A || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_discard: resp=%0d writes=%0d word=%h ready=%0b required 0 0 5a5a5a5a 1",
                     seen, wr_count - wr0, mem[2], req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int nresp = 0;
        int cyc = 0;
        int acc_cyc [3] = '{0, 0, 0};
        logic [32:0] e;
        logic        w_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  s_t [3] = '{2'd2, 2'd2, 2'd0};
        logic [31:0] a_t [3] = '{32'h30, 32'h34, 32'h34};
        logic [32:0] x_t [3] = '{33'h013579BDF, 33'h000000000, 33'h0FFFFFF85};
        @(negedge clock);
        req_valid = 1'b1;
        while (nresp < 3 && cyc < 40) begin
            if (resp_valid) begin
                e = exp_q.pop_front();
                checks++;
                if ({resp_error, resp_rdata} !== e || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_resp[%0d]: data=%h ready=%0b required data=%h ready=0",
                             nresp, {resp_error, resp_rdata}, req_ready, e);
                end
                nresp++;
            end
            if (n < 3 && req_ready) begin
                req_write = w_t[n]; req_size = s_t[n]; req_signed = 1'b1;
                req_address = a_t[n]; req_wdata = 32'h00000085;
                exp_q.push_back(x_t[n]);
                acc_cyc[n] = cyc;
                n++;
            end else if (n == 3) begin
                req_valid = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        req_valid = 1'b0;
        checks++;
        if (nresp !== 3 || n !== 3 || acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin
            errors++;
            $display("FAIL b2b_timing: resp=%0d accepts=%0d gaps=%0d,%0d required 3 3 3,3",
                     nresp, n, acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[2]  = 32'hCAFEF00D;
        mem[8]  = 32'h80FF7F01;
        mem[12] = 32'h13579BDF;
        test_reset();
        test_word();
        test_rmw();
        test_loads();
        test_misalign();
        test_random_bytes();
        test_reset_midop();
        test_back_to_back();
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and one reset. Reset SHALL be asynchronous and active-high. Ports SHALL be:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  CPU access request.
- req_ready  out  1  high only in IDLE with reset low.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_address  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  access rejected; qualified by resp_valid.
- mem_address  out  30  word address to data_memory.
- mem_write_enable  out  1  data_memory write strobe.
- mem_write_input  out  32  data_memory write data.
- mem_read_result  in  32  data_memory combinational read data.

Function
REQ-003 The FSM SHALL have four states: IDLE, READ, WRITE, RESP.
REQ-004 A request SHALL be accepted at a posedge with req_valid && req_ready. All request fields SHALL be latched at that edge; later input changes SHALL have no effect.
REQ-005 Byte order SHALL be little-endian: byte offset k occupies bits [8k+7:8k]; a halfword at offset 2 occupies [31:16].
REQ-006 mem_address SHALL equal latched address[31:2] in READ and WRITE, and SHALL be 0 otherwise.
REQ-007 mem_write_enable SHALL be 1 only in WRITE.
REQ-008 Transitions after acceptance:
- load: IDLE->READ->RESP->IDLE; resp_valid in the 2nd cycle after the accept edge.
- word store: IDLE->WRITE->RESP.
- byte/half store: IDLE->READ->WRITE->RESP (read-modify-write); resp_valid in the 3rd cycle.
REQ-009 In READ, mem_read_result SHALL be captured at the posedge.
REQ-010 The load result SHALL be the addressed byte or half, extended per req_signed to 32 bits. A word load SHALL be passed through unchanged.
REQ-011 For sub-word stores, mem_write_input SHALL be the captured word with only the addressed lane(s) replaced by req_wdata[7:0] or [15:0]. For word stores it SHALL equal req_wdata.
REQ-012 resp_valid SHALL be high for exactly one cycle, in RESP. There is no response backpressure.
REQ-013 Back-to-back: a new request SHALL be acceptable in the cycle after RESP (IDLE), never in RESP.
REQ-014 resp_rdata and resp_error SHALL be held at 0 whenever resp_valid is 0.

Reset
REQ-015 When reset asserts, state SHALL go to IDLE immediately, asynchronously, including mid-operation. The pending request SHALL be discarded with no response and no partial write.
REQ-016 While reset is high: req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, mem_address=0, mem_write_enable=0, mem_write_input=0.

Configuration
REQ-017 With macro LSU_MISALIGN_TRAP_EN defined, each of the following SHALL go IDLE->RESP with resp_error=1, no memory access, and resp_valid in the 1st cycle after accept:
- halfword with address[0]=1,
- word with address[1:0]!=0,
- req_size=11.
REQ-018 Without LSU_MISALIGN_TRAP_EN:
- offending low address bits SHALL be masked to natural alignment;
- size 11 SHALL be treated as word;
- resp_error SHALL be constant 0.

Verification
REQ-019 Reset, then word store 0xAABBCCDD @0x10 -> WRITE cycle: mem_address=4, mem_write_enable=1, mem_write_input=0xAABBCCDD. Word load @0x10 -> resp_rdata=0xAABBCCDD, 2 cycles after accept.
REQ-020 Byte store 0x11 @0x12 over word 0xAABBCCDD -> READ then WRITE with mem_write_input=0xAA11CCDD; resp_valid 3 cycles after accept.
REQ-021 With word 0x80FF7F01 @0x20:
- lb @0x21 signed -> 0x0000007F
- lb @0x22 signed -> 0xFFFFFFFF
- lbu @0x22 -> 0x000000FF
- lh @0x22 signed -> 0xFFFF80FF
- lhu -> 0x000080FF
REQ-022 Misaligned word load @0x13:
- with LSU_MISALIGN_TRAP_EN: resp_error=1, resp_rdata=0, mem_write_enable never high.
- without: treated as load @0x10.
REQ-023 Half store @0x08 accepted, reset asserted during READ -> mem_write_enable never asserts, no resp_valid, word @0x08 unchanged afterward.
REQ-024 Three back-to-back requests with req_valid held high -> accepts only in IDLE cycles, exactly three resp_valid pulses, req_ready=0 outside IDLE.
